// File: rtl/ysyx_22040759_mem_stage_pkg.sv
// Shared types for the MEM stage: bus layouts, access-size encodings and FSM states.
// The packed structs are the single definition of the EXE->MEM and MEM->WB field offsets.
package ysyx_22040759_mem_stage_pkg;

    localparam int XLEN     = 64;
    localparam int ES_BUS_W = 173;
    localparam int WS_BUS_W = 232;

    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_D  = 3'b011,
        F3_BU = 3'b100,
        F3_HU = 3'b101,
        F3_WU = 3'b110
    } func3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } ms_state_e;

    typedef enum logic [1:0] {
        WSEL_ALU = 2'd0,
        WSEL_MEM = 2'd1,
        WSEL_PC  = 2'd2,
        WSEL_CSR = 2'd3
    } wreg_sel_e;

    // Field order is MSB first and must match the EXE stage packing.
    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] src2;
        logic            mem_wen;
        logic            mem_ren;
        logic [2:0]      func3;
        wreg_sel_e       wreg_sel;
        logic            reg_wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
    } es_bus_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] alu_result;
        wreg_sel_e       wreg_sel;
        logic            reg_wen;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
    } ws_bus_t;

endpackage

// File: rtl/ysyx_22040759_mem_stage_if.sv
// Data-memory channel driven by the MEM stage: split address and data handshakes.
interface ysyx_22040759_mem_stage_if;
    import ysyx_22040759_mem_stage_pkg::*;

    logic            data_req;
    logic            data_we;
    logic [XLEN-1:0] data_addr;
    logic [7:0]      data_wstrb;
    logic [XLEN-1:0] data_wdata;
    logic            data_addr_ok;
    logic            data_data_ok;
    logic [XLEN-1:0] data_rdata;

    modport master (
        output data_req, data_we, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_we, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/ysyx_22040759_lsu_fmt.sv
// Combinational lane steering: store strobes/data from the byte offset, and
// sign- or zero-extended load data picked out of an aligned 8-byte word.
module ysyx_22040759_lsu_fmt
    import ysyx_22040759_mem_stage_pkg::*;
(
    input  logic [2:0]      func3,
    input  logic [2:0]      off,
    input  logic [XLEN-1:0] src2,
    input  logic [XLEN-1:0] rdata,
    output logic [7:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [5:0]      bit_off;
    logic [XLEN-1:0] lane;

    // Strobe bits pushed past byte 7 by a misaligned offset simply fall off.
    always_comb begin
        bit_off = {off, 3'b000};
        wdata   = src2 << bit_off;
        lane    = rdata >> bit_off;

        case (func3[1:0])
            2'b00:   wstrb = 8'h01 << off;
            2'b01:   wstrb = 8'h03 << off;
            2'b10:   wstrb = 8'h0F << off;
            default: wstrb = 8'hFF;
        endcase

        case (func3)
            F3_B:    load_data = {{56{lane[7]}},  lane[7:0]};
            F3_H:    load_data = {{48{lane[15]}}, lane[15:0]};
            F3_W:    load_data = {{32{lane[31]}}, lane[31:0]};
            F3_D:    load_data = lane;
            F3_BU:   load_data = {56'b0, lane[7:0]};
            F3_HU:   load_data = {48'b0, lane[15:0]};
            F3_WU:   load_data = {32'b0, lane[31:0]};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22040759_mem_stage.sv
// MEM pipeline stage: latches the EXE bus, runs one data-memory access per
// load/store and holds the pipeline via allowin until the access completes.
module ysyx_22040759_mem_stage
    import ysyx_22040759_mem_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    input  logic [XLEN-1:0]     es_alu_result,
    output logic                ms_allowin,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [WS_BUS_W-1:0] ms_to_ws_bus,
    output logic [XLEN-1:0]     ms_alu_result,
    output logic [4:0]          ms_rd,
    output logic                ms_reg_wen,
    output logic                ms_load_busy,
    ysyx_22040759_mem_stage_if.master dmem
);

    ms_state_e       state_q, state_d;
    logic            ms_valid_q, ms_valid_d;
    es_bus_t         es_bus_q, es_bus_d;
    logic [XLEN-1:0] alu_result_q, alu_result_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    es_bus_t         es_bus_in;
    ws_bus_t         ws_bus;
    logic            mem_op;
    logic            is_load;
    logic            es_is_mem;
    logic            ms_ready_go;
    logic            accept;
    logic            data_req;
    logic            rdata_capture;
    logic [7:0]      fmt_wstrb;
    logic [XLEN-1:0] fmt_wdata;
    logic [XLEN-1:0] fmt_load_data;

    assign es_bus_in = es_bus_t'(es_to_ms_bus);
    assign es_is_mem = es_bus_in.mem_ren | es_bus_in.mem_wen;
    assign mem_op    = ms_valid_q & (es_bus_q.mem_ren | es_bus_q.mem_wen);
    // A request with both enables set is treated as a store.
    assign is_load   = es_bus_q.mem_ren & ~es_bus_q.mem_wen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (mem_op) state_d = ST_ADDR;
            ST_ADDR: if (dmem.data_addr_ok) state_d = dmem.data_data_ok ? ST_HOLD : ST_DATA;
            ST_DATA: if (dmem.data_data_ok) state_d = ST_HOLD;
            // Back-to-back accesses skip IDLE and issue in the cycle after the hand-off.
            ST_HOLD: if (ws_allowin) state_d = (accept && es_is_mem) ? ST_ADDR : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_req      = (state_q == ST_ADDR);
        ms_ready_go   = !mem_op || (state_q == ST_HOLD);
        rdata_capture = dmem.data_data_ok &&
                        (((state_q == ST_ADDR) && dmem.data_addr_ok) || (state_q == ST_DATA));
        ms_load_busy  = ms_valid_q & es_bus_q.mem_ren & (state_q != ST_HOLD);
    end

    always_comb begin
        ms_allowin   = !ms_valid_q || (ms_ready_go && ws_allowin);
        accept       = es_to_ms_valid && ms_allowin;
        ms_valid_d   = ms_allowin ? es_to_ms_valid : ms_valid_q;
        es_bus_d     = accept ? es_bus_in : es_bus_q;
        alu_result_d = accept ? es_alu_result : alu_result_q;
        rdata_d      = rdata_capture ? dmem.data_rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_valid_q   <= 1'b0;
            es_bus_q     <= '0;
            alu_result_q <= '0;
            rdata_q      <= '0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            es_bus_q     <= es_bus_d;
            alu_result_q <= alu_result_d;
            rdata_q      <= rdata_d;
        end
    end

    ysyx_22040759_lsu_fmt u_lsu_fmt (
        .func3     (es_bus_q.func3),
        .off       (alu_result_q[2:0]),
        .src2      (es_bus_q.src2),
        .rdata     (rdata_q),
        .wstrb     (fmt_wstrb),
        .wdata     (fmt_wdata),
        .load_data (fmt_load_data)
    );

    assign dmem.data_req   = data_req;
    assign dmem.data_we    = es_bus_q.mem_wen;
    assign dmem.data_addr  = {alu_result_q[XLEN-1:3], 3'b000};
    assign dmem.data_wstrb = es_bus_q.mem_wen ? fmt_wstrb : 8'h00;
    assign dmem.data_wdata = fmt_wdata;

    always_comb begin
        ws_bus.inst       = es_bus_q.inst;
        ws_bus.mem_rdata  = is_load ? fmt_load_data : '0;
        ws_bus.alu_result = alu_result_q;
        ws_bus.wreg_sel   = es_bus_q.wreg_sel;
        ws_bus.reg_wen    = es_bus_q.reg_wen;
        ws_bus.rd         = es_bus_q.rd;
        ws_bus.pc         = es_bus_q.pc;
    end

    assign ms_to_ws_bus   = ws_bus;
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign ms_alu_result  = alu_result_q;
    assign ms_rd          = es_bus_q.rd;
    assign ms_reg_wen     = ms_valid_q & es_bus_q.reg_wen;

endmodule
